// File: rtl/ntt_rej_sampler_if.sv
// rtl/ntt_rej_sampler_if.sv - byte-in / coefficient-out handshake bundle of the rejection sampler
interface ntt_rej_sampler_if #(
  parameter int CW = 12,
  parameter int IW = 8
);
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic [7:0]    byte_i;
  logic          byte_valid_i;
  logic          byte_ready_o;
  logic [CW-1:0] coeff_o;
  logic [IW-1:0] coeff_idx_o;
  logic          coeff_valid_o;
  logic          coeff_ready_i;
  logic          coeff_last_o;
  logic [15:0]   rej_cnt_o;

  modport master (
    input  start_i, byte_i, byte_valid_i, coeff_ready_i,
    output busy_o, done_o, byte_ready_o, coeff_o, coeff_idx_o,
           coeff_valid_o, coeff_last_o, rej_cnt_o
  );

  modport slave (
    output start_i, byte_i, byte_valid_i, coeff_ready_i,
    input  busy_o, done_o, byte_ready_o, coeff_o, coeff_idx_o,
           coeff_valid_o, coeff_last_o, rej_cnt_o
  );
endinterface

// File: rtl/ntt_rej_sampler.sv
// rtl/ntt_rej_sampler.sv - parses XOF bytes into 12-bit candidates, rejects >= Q, emits N indexed coefficients
module ntt_rej_sampler #(
  parameter int Q  = 3329,
  parameter int N  = 256,
  parameter int CW = 12,
  parameter int IW = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  ntt_rej_sampler_if.master   bus
);
  typedef enum logic [2:0] {IDLE, B0, B1, B2, OUT1, OUT2, DONE} state_e;

  localparam logic [CW-1:0] QV   = CW'(Q);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_e        state_q;
  logic [7:0]    b0_q, b1_q;
  logic [CW-1:0] d1_q, d2_q;
  logic [IW-1:0] count_q;
  logic [15:0]   rej_q;
  logic          busy_q, done_q, byte_ready_q, coeff_valid_q, coeff_last_q;
  logic [CW-1:0] coeff_q;
  logic [IW-1:0] coeff_idx_q;

  // Candidates are formed from the two stored bytes plus the byte arriving in B2.
  logic [CW-1:0] c1, c2;
  logic          c1_ok, c2_ok, byte_hs;
  logic [1:0]    rej_inc;
  logic [16:0]   rej_sum;
  logic [IW-1:0] count_nxt;

  assign c1        = {b1_q[3:0], b0_q};
  assign c2        = {bus.byte_i, b1_q[7:4]};
  assign c1_ok     = c1 < QV;
  assign c2_ok     = c2 < QV;
  assign rej_inc   = {1'b0, ~c1_ok} + {1'b0, ~c2_ok};
  assign rej_sum   = {1'b0, rej_q} + 17'(rej_inc);
  assign byte_hs   = byte_ready_q & bus.byte_valid_i;
  assign count_nxt = count_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      b0_q          <= '0;
      b1_q          <= '0;
      d1_q          <= '0;
      d2_q          <= '0;
      count_q       <= '0;
      rej_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      byte_ready_q  <= 1'b0;
      coeff_valid_q <= 1'b0;
      coeff_last_q  <= 1'b0;
      coeff_q       <= '0;
      coeff_idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            state_q      <= B0;
            count_q      <= '0;
            rej_q        <= '0;
            busy_q       <= 1'b1;
            byte_ready_q <= 1'b1;
          end
        end
        B0: begin
          if (byte_hs) begin
            b0_q    <= bus.byte_i;
            state_q <= B1;
          end
        end
        B1: begin
          if (byte_hs) begin
            b1_q    <= bus.byte_i;
            state_q <= B2;
          end
        end
        B2: begin
          if (byte_hs) begin
            d1_q  <= c1;
            d2_q  <= c2;
            rej_q <= rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
            if (c1_ok) begin
              state_q       <= OUT1;
              byte_ready_q  <= 1'b0;
              coeff_valid_q <= 1'b1;
              coeff_q       <= c1;
              coeff_idx_q   <= count_q;
              coeff_last_q  <= (count_q == LAST);
            end else if (c2_ok) begin
              state_q       <= OUT2;
              byte_ready_q  <= 1'b0;
              coeff_valid_q <= 1'b1;
              coeff_q       <= c2;
              coeff_idx_q   <= count_q;
              coeff_last_q  <= (count_q == LAST);
            end else begin
              state_q <= B0;
            end
          end
        end
        OUT1, OUT2: begin
          if (bus.coeff_ready_i) begin
            count_q <= count_nxt;
            if (count_q == LAST) begin
              // A pending valid d2 is dropped once the polynomial is full.
              state_q       <= DONE;
              coeff_valid_q <= 1'b0;
              coeff_last_q  <= 1'b0;
              done_q        <= 1'b1;
            end else if (state_q == OUT1 && d2_q < QV) begin
              state_q      <= OUT2;
              coeff_q      <= d2_q;
              coeff_idx_q  <= count_nxt;
              coeff_last_q <= (count_nxt == LAST);
            end else begin
              state_q       <= B0;
              coeff_valid_q <= 1'b0;
              coeff_last_q  <= 1'b0;
              byte_ready_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.byte_ready_o  = byte_ready_q;
  assign bus.coeff_o       = coeff_q;
  assign bus.coeff_idx_o   = coeff_idx_q;
  assign bus.coeff_valid_o = coeff_valid_q;
  assign bus.coeff_last_o  = coeff_last_q;
  assign bus.rej_cnt_o     = rej_q;
endmodule

// File: doc/ntt_rej_sampler.md
Name: ntt_rej_sampler

Overview:
Upstream coefficient source for the NTT load path. Consumes a byte stream (XOF/SHAKE output) and parses each 3-byte group into two 12-bit candidates. Candidates >= Q are rejected. Accepted values are emitted as an indexed coefficient stream until exactly N coefficients are produced, then done_o pulses. The output stream feeds the serial coefficient loader in front of the NTT core one coefficient per handshake.

Parameters:
Q, 3329, modulus; candidates >= Q rejected
N, 256, coefficients per polynomial (power of 2)
CW, 12, coefficient/candidate width
IW, 8, index width, log2(N)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  begin one polynomial; honoured only in IDLE
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse after the N-th coefficient handshake
byte_i  in  8  input byte
byte_valid_i  in  1  byte_i valid
byte_ready_o  out  1  block accepts byte_i
coeff_o  out  CW  accepted coefficient, < Q
coeff_idx_o  out  IW  index of coeff_o, 0..N-1
coeff_valid_o  out  1  coeff_o valid
coeff_ready_i  in  1  downstream accepts coeff_o
coeff_last_o  out  1  high with coeff_valid_o when coeff_idx_o == N-1
rej_cnt_o  out  16  rejected candidates this polynomial, saturating at 0xFFFF

Behaviour:
- Reset: state IDLE; all outputs 0; count, rej_cnt, byte/candidate registers 0.
- States: IDLE, B0, B1, B2, OUT1, OUT2, DONE.
- IDLE: start_i=1 -> B0; clear count and rej_cnt.
- B0/B1/B2: byte_ready_o=1. On byte handshake, store b0/b1/b2 and advance.
- On the B2 handshake, register both candidates:
  - d1 = b0 + 256*(b1 & 0xF)
  - d2 = (b1 >> 4) + 16*b2
  - Each candidate is 12 bits; no overflow is possible.
- Next state from B2: OUT1 if d1<Q; else OUT2 if d2<Q; else B0.
- rej_cnt increments by the number of rejected candidates in the triple (0, 1 or 2), saturating.
- OUT1/OUT2:
  - coeff_valid_o=1, coeff_o=d1 or d2, coeff_idx_o=count; byte_ready_o=0.
  - coeff_o, coeff_idx_o and coeff_last_o hold stable until coeff_ready_i=1.
  - On handshake: count++.
  - If count was N-1 -> DONE.
  - Else from OUT1: OUT2 if d2<Q, otherwise B0. From OUT2: B0.
- Completion on d1: when d1 completes the polynomial, d2 is discarded even if valid. It is not counted in rej_cnt.
- DONE: done_o=1 for exactly one cycle, busy_o stays 1, byte_ready_o=0; next cycle -> IDLE. rej_cnt_o holds until the next start_i.
- Bytes not consumed after completion are the upstream's responsibility; byte_ready_o stays 0 in IDLE and DONE.
- start_i outside IDLE is ignored.
- byte_valid_i and coeff_ready_i may toggle arbitrarily; there is no combinational path from either to byte_ready_o or coeff_valid_o.
- Throughput: 3 cycles per triple plus 1 cycle per emitted coefficient, without backpressure.
- rst_ni asserted mid-operation: immediate return to reset state. A partial triple is lost and no done_o pulse is produced.

Test Plan:
- start_i, bytes 0x01,0x02,0x03 -> coeff 513 idx 0, then coeff 48 idx 1; rej_cnt_o=0.
- Bytes 0x00,0x0D,0xD0 -> 3328 idx0 and 3328 idx1. Then bytes 0x01,0x1D,0xD0 -> both 3329, no output, rej_cnt_o=2.
- Bytes 0xFF,0xFF,0xFF -> no coeff_valid_o, rej_cnt_o=2, byte_ready_o high again 1 cycle after the third byte handshake.
- Completion:
  - Stimulus: 127 triples 0x01,0x02,0x03 (idx 0..253); triple 0x05,0x00,0xFF (5 at idx254, 4080 rejected); triple 0x07,0x00,0x01.
  - Response: coeff 7 at idx255 with coeff_last_o=1, the 16 is dropped. done_o pulses one cycle after that handshake, then IDLE with byte_ready_o=0. rej_cnt_o=1.
- Hold coeff_ready_i=0 for 5 cycles while in OUT1 -> coeff_o, coeff_idx_o stable; byte_ready_o=0; no count change.
- Assert rst_ni low after 100 coefficients -> all outputs 0 and IDLE. A fresh start_i restarts at idx 0.
